mac_filter: RTL and testbench

//  Parametrised destination-MAC filter for the DELQA receive path; successor to the fixed 14-entry comparator.

---
 rtl/delqa_pkg.sv | 37 +++
 rtl/mac_filter_regs.sv | 103 ++++++++++
 rtl/mac_filter.sv | 156 +++++++++++++++
 tb/tb_mac_filter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delqa_pkg.sv
// rtl/delqa_pkg.sv - shared constants, register offsets and FSM state type for the DELQA MAC filter
package delqa_pkg;

  localparam int MAC_W = 48;

  localparam int PMS_SETUP   = 0;
  localparam int PMS_ALLMC   = 1;
  localparam int PMS_PROMISC = 2;

  localparam logic [2:0] REG_IDX   = 3'd0;
  localparam logic [2:0] REG_STG1  = 3'd1;
  localparam logic [2:0] REG_STG2  = 3'd2;
  localparam logic [2:0] REG_MACH  = 3'd3;
  localparam logic [2:0] REG_VALID = 3'd4;
  localparam logic [2:0] REG_HASH0 = 3'd5;
  localparam logic [2:0] REG_HASH1 = 3'd6;
  localparam logic [2:0] REG_HASH2 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } macf_state_e;

  // Multicast hash bucket: bit j is the XOR of MAC bits j, j+6, ..., j+42.
  function automatic logic [5:0] hash_bucket(input logic [MAC_W-1:0] mac);
    logic [5:0] b;
    b = '0;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 8; i++) begin
        b[j] = b[j] ^ mac[j + 6 * i];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/mac_filter_regs.sv
// rtl/mac_filter_regs.sv - address table, valid bits, staging registers, read mux and scan comparator
// Optional multicast hash table enabled by `define MACF_HASH_EN.
module mac_filter_regs
  import delqa_pkg::*;
#(
  parameter int N_ENT = 14,
  parameter int IW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [2:0]       adr_i,
  input  logic [15:0]      dat_i,
  output logic [15:0]      rd_dat_o,
  input  logic [IW-1:0]    cmp_ptr_i,
  input  logic [MAC_W-1:0] cmp_mac_i,
`ifdef MACF_HASH_EN
  output logic [63:0]      hash_o,
`endif
  output logic             cmp_match_o
);

  localparam logic [IW:0] N_ENT_W = (IW+1)'(N_ENT);

  logic [MAC_W-1:0] entry_q [N_ENT];
  logic [N_ENT-1:0] valid_q;
  logic [IW-1:0]    idx_q;
  logic [15:0]      stg1_q;
  logic [15:0]      stg2_q;
  logic             idx_ok;
  logic [MAC_W-1:0] entry_sel;

  assign idx_ok = ({1'b0, idx_q} < N_ENT_W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      idx_q   <= '0;
      stg1_q  <= '0;
      stg2_q  <= '0;
    end else if (wr_i) begin
      case (adr_i)
        REG_IDX: begin
          idx_q <= dat_i[IW-1:0];
          if (dat_i[15]) valid_q <= '0;
        end
        REG_STG1: stg1_q <= dat_i;
        REG_STG2: stg2_q <= dat_i;
        REG_MACH: if (idx_ok) valid_q[idx_q] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Entry contents need no reset; the valid bits gate every use of them.
  always_ff @(posedge clk_i) begin
    if (wr_i && adr_i == REG_MACH && idx_ok) begin
      entry_q[idx_q] <= {dat_i, stg2_q, stg1_q};
    end
  end

`ifdef MACF_HASH_EN
  logic [63:0] hash_q;

  // Reg 4 stays the read-only valid mask on reads; writes there load hash[63:48].
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hash_q <= '0;
    end else if (wr_i) begin
      case (adr_i)
        REG_HASH0: hash_q[15:0]  <= dat_i;
        REG_HASH1: hash_q[31:16] <= dat_i;
        REG_HASH2: hash_q[47:32] <= dat_i;
        REG_VALID: hash_q[63:48] <= dat_i;
        default: ;
      endcase
    end
  end

  assign hash_o = hash_q;
`endif

  always_comb begin
    rd_dat_o  = '0;
    entry_sel = idx_ok ? entry_q[idx_q] : '0;
    case (adr_i)
      REG_IDX:   rd_dat_o[IW-1:0] = idx_q;
      REG_STG1:  rd_dat_o = entry_sel[15:0];
      REG_STG2:  rd_dat_o = entry_sel[31:16];
      REG_MACH:  rd_dat_o = entry_sel[47:32];
      REG_VALID: rd_dat_o[N_ENT-1:0] = valid_q;
`ifdef MACF_HASH_EN
      REG_HASH0: rd_dat_o = hash_q[15:0];
      REG_HASH1: rd_dat_o = hash_q[31:16];
      REG_HASH2: rd_dat_o = hash_q[47:32];
`endif
      default: ;
    endcase
  end

  assign cmp_match_o = valid_q[cmp_ptr_i] && (entry_q[cmp_ptr_i] == cmp_mac_i);

endmodule

// File: rtl/mac_filter.sv
// rtl/mac_filter.sv - destination-MAC filter top: Wishbone ack/read path and scan FSM
// Optional multicast hash acceptance enabled by `define MACF_HASH_EN.
module mac_filter
  import delqa_pkg::*;
#(
  parameter int N_ENT = 14,
  parameter int IW    = 4
) (
  input  logic             wb_clk_i,
  input  logic             rst_i,
  input  logic [2:0]       wb_adr_i,
  input  logic [15:0]      wb_dat_i,
  output logic [15:0]      wb_dat_o,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [1:0]       wb_sel_i,
  output logic             wb_ack_o,
  input  logic [2:0]       eth_pms_i,
  input  logic             eth_macr_i,
  input  logic [MAC_W-1:0] eth_macd_i,
  output logic             cmp_done_o,
  output logic             cmp_res_o,
  output logic [IW-1:0]    cmp_hit_o
);

  localparam logic [IW-1:0] LAST_PTR = IW'(N_ENT - 1);
  localparam logic [IW-1:0] HIT_NONE = '1;

  logic             setup;
  logic             promisc;
  logic             allmc;
  logic             ack_d;
  logic             ack_q;
  logic             wr;
  logic [15:0]      rd_dat;
  logic [15:0]      dat_q;
  logic             match;
  logic             fast_accept;
  macf_state_e      state_q;
  logic [IW-1:0]    ptr_q;
  logic [MAC_W-1:0] mac_q;
  logic             done_q;
  logic             res_q;
  logic [IW-1:0]    hit_q;

  assign setup   = eth_pms_i[PMS_SETUP];
  assign allmc   = eth_pms_i[PMS_ALLMC];
  assign promisc = eth_pms_i[PMS_PROMISC];

  // One access per ack: a strobe held across the ack cycle is not taken twice in a row.
  assign ack_d = wb_cyc_i && wb_stb_i && !ack_q;
  assign wr    = ack_d && wb_we_i && (wb_sel_i == 2'b11) && setup;

`ifdef MACF_HASH_EN
  logic [63:0] hash;

  assign fast_accept = promisc || (eth_macd_i[0] && (allmc || hash[hash_bucket(eth_macd_i)]));
`else
  assign fast_accept = promisc || (allmc && eth_macd_i[0]);
`endif

  mac_filter_regs #(
    .N_ENT(N_ENT),
    .IW   (IW)
  ) u_regs (
    .clk_i      (wb_clk_i),
    .rst_i      (rst_i),
    .wr_i       (wr),
    .adr_i      (wb_adr_i),
    .dat_i      (wb_dat_i),
    .rd_dat_o   (rd_dat),
    .cmp_ptr_i  (ptr_q),
    .cmp_mac_i  (mac_q),
`ifdef MACF_HASH_EN
    .hash_o     (hash),
`endif
    .cmp_match_o(match)
  );

  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      if (ack_d) dat_q <= setup ? rd_dat : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      mac_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= 1'b0;
      hit_q   <= HIT_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eth_macr_i && !setup) begin
            mac_q <= eth_macd_i;
            ptr_q <= '0;
            if (fast_accept) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              res_q   <= 1'b1;
              hit_q   <= HIT_NONE;
            end else begin
              state_q <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (setup || !eth_macr_i) begin
            state_q <= ST_IDLE;
          end else if (match) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            res_q   <= 1'b1;
            hit_q   <= ptr_q;
          end else if (ptr_q == LAST_PTR) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            res_q   <= 1'b0;
            hit_q   <= HIT_NONE;
          end else begin
            ptr_q <= ptr_q + IW'(1);
          end
        end
        ST_DONE: begin
          if (setup || !eth_macr_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            res_q   <= 1'b0;
            hit_q   <= HIT_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          res_q   <= 1'b0;
          hit_q   <= HIT_NONE;
        end
      endcase
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign cmp_done_o = done_q;
  assign cmp_res_o  = res_q;
  assign cmp_hit_o  = hit_q;

endmodule

// File: tb/tb_mac_filter.sv
// tb/tb_mac_filter.sv - directed self-checking bench for mac_filter (hash steps only with MACF_HASH_EN)
module tb_mac_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  adr;
  logic [15:0] dat_w;
  logic [15:0] dat_r;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  sel;
  logic        ack;
  logic [2:0]  pms;
  logic        macr;
  logic [47:0] macd;
  logic        done;
  logic        res;
  logic [3:0]  hit;

  int tests = 0;
  int fails = 0;

  mac_filter #(.N_ENT(14), .IW(4)) dut (
    .wb_clk_i  (clk),
    .rst_i     (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_dat_o  (dat_r),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_ack_o  (ack),
    .eth_pms_i (pms),
    .eth_macr_i(macr),
    .eth_macd_i(macd),
    .cmp_done_o(done),
    .cmp_res_o (res),
    .cmp_hit_o (hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
    @(negedge clk);
    adr = a; dat_w = d; we = 1'b1; sel = s; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("wr_ack", {47'd0, ack}, 48'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    adr = a; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    d = dat_r;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    chk(tag, {32'd0, d}, {32'd0, exp});
  endtask

  task automatic commit(input logic [3:0] idx, input logic [47:0] mac);
    bus_wr(3'd0, {12'd0, idx}, 2'b11);
    bus_wr(3'd1, mac[15:0], 2'b11);
    bus_wr(3'd2, mac[31:16], 2'b11);
    bus_wr(3'd3, mac[47:32], 2'b11);
  endtask

  // Raises macr at a negedge (cycle 0) and counts rising edges until done is seen.
  task automatic lookup(input string tag, input logic [47:0] mac, input int exp_n,
                        input logic exp_res, input logic [3:0] exp_hit);
    int n;
    @(negedge clk);
    macd = mac; macr = 1'b1; n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!done && n < 40);
    chk({tag, "_lat"}, 48'(n), 48'(exp_n));
    chk({tag, "_res"}, {47'd0, res}, {47'd0, exp_res});
    chk({tag, "_hit"}, {44'd0, hit}, {44'd0, exp_hit});
  endtask

  task automatic release_req(input string tag);
    macr = 1'b0;
    @(negedge clk);
    chk({tag, "_rel_done"}, {47'd0, done}, 48'd0);
    chk({tag, "_rel_hit"}, {44'd0, hit}, 48'hF);
  endtask

  localparam logic [47:0] MAC_A = 48'h0800_2B11_2233;
  localparam logic [47:0] MAC_L = 48'h0800_2B00_0D0D;
  localparam logic [47:0] MAC_B = 48'h0800_2B00_0505;

  initial begin
    logic seen;
    rst = 1'b1; adr = '0; dat_w = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 2'b00;
    pms = 3'b000; macr = 1'b0; macd = '0;
    #12;
    chk("rst_done", {47'd0, done}, 48'd0);
    chk("rst_res", {47'd0, res}, 48'd0);
    chk("rst_hit", {44'd0, hit}, 48'hF);
    chk("rst_ack", {47'd0, ack}, 48'd0);
    chk("rst_dat", {32'd0, dat_r}, 48'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table load and readback
    pms = 3'b001;
    commit(4'd2, MAC_A);
    @(negedge clk);
    chk("ack_drop", {47'd0, ack}, 48'd0);
    rd_chk("mask_a", 3'd4, 16'h0004);
    rd_chk("rd_mach", 3'd3, 16'h0800);
    rd_chk("rd_lo", 3'd1, 16'h2233);
    rd_chk("rd_idx", 3'd0, 16'h0002);
    commit(4'd13, MAC_L);
    rd_chk("mask_al", 3'd4, 16'h2004);
    commit(4'd14, 48'hBBBB_CCCC_AAAA);
    rd_chk("mask_oob", 3'd4, 16'h2004);
    rd_chk("rd_oob", 3'd3, 16'h0000);
    bus_wr(3'd0, 16'h8000, 2'b01);
    rd_chk("sel_ign_mask", 3'd4, 16'h2004);
    rd_chk("sel_ign_idx", 3'd0, 16'h000E);
    pms = 3'b000;
    rd_chk("nosetup_rd", 3'd4, 16'h0000);
    bus_wr(3'd0, 16'h8000, 2'b11);

    // Hit, miss, last-entry hit
    lookup("t1", MAC_A, 4, 1'b1, 4'd2);
    repeat (3) @(negedge clk);
    chk("t1_hold_done", {47'd0, done}, 48'd1);
    chk("t1_hold_hit", {44'd0, hit}, 48'd2);
    release_req("t1");
    lookup("t2", 48'h0800_2B00_0001, 15, 1'b0, 4'hF);
    release_req("t2");
    lookup("last", MAC_L, 15, 1'b1, 4'd13);
    release_req("last");

    // Promiscuous and all-multicast
    pms = 3'b100;
    lookup("prom", 48'h1234_5678_9ABC, 1, 1'b1, 4'hF);
    release_req("prom");
    pms = 3'b010;
    lookup("allmc", 48'h0100_0000_0001, 1, 1'b1, 4'hF);
    release_req("allmc");
    lookup("allmc_uc", 48'h0800_2B00_0002, 15, 1'b0, 4'hF);
    release_req("allmc_uc");

    // Clear all
    pms = 3'b001;
    bus_wr(3'd0, 16'h8000, 2'b11);
    rd_chk("clr_mask", 3'd4, 16'h0000);
    pms = 3'b000;
    lookup("clr", MAC_A, 15, 1'b0, 4'hF);
    release_req("clr");

    // Abort by macr drop, then a clean rescan
    pms = 3'b001;
    commit(4'd5, MAC_B);
    pms = 3'b000;
    @(negedge clk);
    macd = MAC_B; macr = 1'b1; seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= done;
    end
    macr = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= done;
    end
    chk("abort_nodone", {47'd0, seen}, 48'd0);
    lookup("rescan", MAC_B, 7, 1'b1, 4'd5);
    release_req("rescan");

    // Abort by setup during scan
    @(negedge clk);
    macd = MAC_B; macr = 1'b1; seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= done;
    end
    pms = 3'b001;
    repeat (8) begin
      @(negedge clk);
      seen |= done;
    end
    macr = 1'b0;
    @(negedge clk);
    pms = 3'b000;
    chk("setup_abort", {47'd0, seen}, 48'd0);

    // Async reset while a result is held
    lookup("pre_rst", MAC_B, 7, 1'b1, 4'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_done", {47'd0, done}, 48'd0);
    chk("arst_res", {47'd0, res}, 48'd0);
    chk("arst_hit", {44'd0, hit}, 48'hF);
    macr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pms = 3'b001;
    rd_chk("arst_mask", 3'd4, 16'h0000);
    pms = 3'b000;

`ifdef MACF_HASH_EN
    // Bucket of 0x0300_0000_0001 is 49, i.e. hash[63:48] bit 1
    pms = 3'b001;
    bus_wr(3'd4, 16'h0002, 2'b11);
    pms = 3'b000;
    lookup("hash_hit", 48'h0300_0000_0001, 1, 1'b1, 4'hF);
    release_req("hash_hit");
    pms = 3'b001;
    bus_wr(3'd4, 16'h0000, 2'b11);
    pms = 3'b000;
    lookup("hash_miss", 48'h0300_0000_0001, 15, 1'b0, 4'hF);
    release_req("hash_miss");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
